// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic multiply unit.
// Used by the feeder, its skew lanes and the array.
package systolic_pkg;

  localparam int K_DEF = 8;
  localparam int D_DEF = 16;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feed_state_t;

  function automatic int step_w(input int d);
    return $clog2(2 * d);
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One lane of the diagonal wavefront: picks vec[t-lane] or 0.
// Signed difference keeps early steps from aliasing into range.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int k = K_DEF,
  parameter int D = D_DEF,
  localparam int SW = step_w(D)
) (
  input  logic [SW-1:0]        t,
  input  logic [SW-1:0]        lane,
  input  logic [0:D-1][k-1:0]  vec,
  output logic [k-1:0]         elem
);

  logic signed [SW:0] d;
  logic               hit;

  assign d   = $signed({1'b0, t}) - $signed({1'b0, lane});
  assign hit = (d >= 0) && (d < $signed((SW+1)'(D)));

  always_comb begin
    elem = '0;
    if (hit) elem = vec[d[SW-1:0]];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers an A/B operand pair and streams the skewed wavefront
// into the systolic array, owning its accumulator clear.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int k     = K_DEF,
  parameter int D     = D_DEF,
  parameter int DRAIN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [0:D-1][k-1:0] ld_a,
  input  logic [0:D-1][k-1:0] ld_b,
  output logic [0:D-1][k-1:0] in_l,
  output logic [0:D-1][k-1:0] in_t,
  output logic                arr_clr,
  output logic                busy,
  output logic                done
);

  localparam int SW = step_w(D);
  localparam int DW = $clog2(DRAIN + 1);

  feed_state_t state, state_n;
  logic [SW-1:0] beat, beat_n;
  logic [SW-1:0] step, step_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          rdy_q;
  logic          acc;

  logic [0:D-1][k-1:0] a_buf [0:D-1];
  logic [0:D-1][k-1:0] b_buf [0:D-1];
  logic [0:D-1][k-1:0] l_nxt, t_nxt;

  assign ld_ready = rdy_q & ~rst;
  assign acc      = ld_valid & (state == LOAD);

  always_comb begin
    state_n = state;
    beat_n  = beat;
    step_n  = step;
    dcnt_n  = dcnt;
    unique case (state)
      LOAD: if (acc) begin
        if (beat == SW'(D - 1)) begin
          state_n = CLEAR;
          beat_n  = '0;
        end else begin
          beat_n = beat + 1'b1;
        end
      end
      CLEAR: begin
        state_n = STREAM;
        step_n  = '0;
      end
      STREAM: if (step == SW'(2 * D - 2)) begin
        state_n = systolic_pkg::DRAIN;
        dcnt_n  = '0;
      end else begin
        step_n = step + 1'b1;
      end
      systolic_pkg::DRAIN: begin
        if (dcnt == DW'(DRAIN - 1)) state_n = DONE;
        else dcnt_n = dcnt + 1'b1;
      end
      DONE: state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // lanes look at next-cycle step so the operands leave registered
  for (genvar g = 0; g < D; g++) begin : g_lane
    systolic_skew_lane #(.k(k), .D(D)) u_l (
      .t    (step_n),
      .lane (SW'(g)),
      .vec  (a_buf[g]),
      .elem (l_nxt[g])
    );
    systolic_skew_lane #(.k(k), .D(D)) u_t (
      .t    (step_n),
      .lane (SW'(g)),
      .vec  (b_buf[g]),
      .elem (t_nxt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      a_buf[beat] <= ld_a;
      b_buf[beat] <= ld_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      beat    <= '0;
      step    <= '0;
      dcnt    <= '0;
      in_l    <= '0;
      in_t    <= '0;
      arr_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      step    <= step_n;
      dcnt    <= dcnt_n;
      in_l    <= (state_n == STREAM) ? l_nxt : '0;
      in_t    <= (state_n == STREAM) ? t_nxt : '0;
      arr_clr <= (state_n == CLEAR);
      busy    <= (state_n != LOAD);
      done    <= (state_n == DONE);
      rdy_q   <= (state_n == LOAD);
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a step scoreboard
// and a reference systolic array fed by the DUT outputs.
module tb_systolic_feeder;

  localparam int k  = 8;
  localparam int D  = 4;
  localparam int DR = 4;

  typedef logic [0:D-1][k-1:0] vec_t;
  typedef struct {
    vec_t l;
    vec_t t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ld_valid;
  logic ld_ready;
  vec_t ld_a, ld_b, in_l, in_t;
  logic arr_clr, busy, done;

  systolic_feeder #(.k(k), .D(D), .DRAIN(DR)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_a     (ld_a),
    .ld_b     (ld_b),
    .in_l     (in_l),
    .in_t     (in_t),
    .arr_clr  (arr_clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   ma [D][D];
  int   mb [D][D];
  vec_t snap_l [2*D-1];
  vec_t snap_t [2*D-1];

  // reference output-stationary array
  int pa [D][D];
  int pb [D][D];
  int pc [D][D];

  function automatic int a_in(int i, int j);
    return (j == 0) ? int'(in_l[i]) : pa[i][j-1];
  endfunction

  function automatic int b_in(int i, int j);
    return (i == 0) ? int'(in_t[j]) : pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        if (rst || arr_clr) begin
          pa[i][j] <= 0;
          pb[i][j] <= 0;
          pc[i][j] <= 0;
        end else begin
          pa[i][j] <= a_in(i, j);
          pb[i][j] <= b_in(i, j);
          pc[i][j] <= pc[i][j] + a_in(i, j) * b_in(i, j);
        end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mats(input int pat);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        case (pat)
          0: begin ma[r][c] = 16*r + c; mb[r][c] = 16*r + c; end
          1: begin ma[r][c] = 1; mb[r][c] = 2; end
          2: begin ma[r][c] = (r == c) ? 1 : 0; mb[r][c] = r + c; end
          default: begin ma[r][c] = 3*r + c + 1; mb[r][c] = 7 - r + 2*c; end
        endcase
  endtask

  task automatic push_exp();
    exp_t e;
    for (int t = 0; t < 2*D-1; t++) begin
      for (int i = 0; i < D; i++) begin
        int d = t - i;
        e.l[i] = (d >= 0 && d < D) ? k'(ma[i][d]) : '0;
        e.t[i] = (d >= 0 && d < D) ? k'(mb[d][i]) : '0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic load(input bit gaps);
    push_exp();
    for (int r = 0; r < D; r++) begin
      if (gaps) begin
        ld_valid = 1'b0;
        @(negedge clk);
      end
      chk("ld_ready_load", ld_ready, 1);
      ld_valid = 1'b1;
      for (int c = 0; c < D; c++) begin
        ld_a[c] = k'(ma[r][c]);
        ld_b[c] = k'(mb[c][r]);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
  endtask

  task automatic check_run(input bit inject, input int rst_at);
    exp_t e;
    int   cref;
    chk("arr_clr", arr_clr, 1);
    chk("clr_in_l", in_l, 0);
    chk("clr_busy", busy, 1);
    chk("clr_ready", ld_ready, 0);
    for (int t = 0; t < 2*D-1; t++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
        return;
      end
      e = sb.pop_front();
      chk($sformatf("in_l_t%0d", t), in_l, e.l);
      chk($sformatf("in_t_t%0d", t), in_t, e.t);
      chk("stream_clr", arr_clr, 0);
      snap_l[t] = in_l;
      snap_t[t] = in_t;
      if (inject && t == 0) begin
        ld_valid = 1'b1;
        ld_a = '1;
        ld_b = '1;
      end else begin
        ld_valid = 1'b0;
      end
      if (t == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_l", in_l, 0);
        chk("rst_in_t", in_t, 0);
        chk("rst_clr", arr_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ld_ready, 1);
        sb.delete();
        return;
      end
    end
    for (int d = 0; d < DR; d++) begin
      @(negedge clk);
      chk("drain_in_l", in_l, 0);
      chk("drain_in_t", in_t, 0);
      chk("drain_done", done, 0);
      chk("drain_ready", ld_ready, 0);
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("done_ready", ld_ready, 0);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        cref = 0;
        for (int x = 0; x < D; x++) cref += ma[i][x] * mb[x][j];
        chk($sformatf("c_%0d%0d", i, j), pc[i][j], cref);
      end
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_ready", ld_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_a = '0;
    ld_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready_hi", ld_ready, 0);
    chk("rst0_busy", busy, 0);
    chk("rst0_done", done, 0);
    chk("rst0_clr", arr_clr, 0);
    chk("rst0_in_l", in_l, 0);
    chk("rst0_in_t", in_t, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", ld_ready, 1);

    // skew pattern, back-to-back, stray valid during stream
    set_mats(0);
    load(1'b0);
    check_run(1'b1, -1);
    chk("skew_s3_l", snap_l[3], 32'h03122130);
    chk("skew_s6_l", snap_l[6], 32'h00000033);
    chk("skew_s6_t3", snap_t[6][3], 8'h33);

    // same data with gaps
    set_mats(0);
    load(1'b1);
    check_run(1'b0, -1);

    // ones times twos
    set_mats(1);
    load(1'b0);
    check_run(1'b0, -1);
    chk("c_ones", pc[2][1], 8);

    // identity times B
    set_mats(2);
    load(1'b1);
    check_run(1'b0, -1);
    chk("c_ident", pc[3][2], 5);

    // reset in the middle of the stream
    set_mats(3);
    load(1'b0);
    check_run(1'b0, 2);
    load(1'b0);
    check_run(1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Front-end transmitter for the `systolic_arr` matrix-multiply array. It buffers a D×D operand pair, matrix A row by row and matrix B column by column, through a valid/ready load port. It then drives the array's `in_l`/`in_t` edges with the diagonally skewed wavefront the array consumes. When the array's accumulators hold C = A·B, it pulses `done`. It also owns the array's accumulator clear, so one feeder plus one array forms a complete multiply unit.

## Interface
- `k`, 8: operand element width in bits.
- `D`, 16: array dimension; A, B and C are D×D.
- `DRAIN`, 16: idle cycles after the last skewed step before `done`. Set it to at least D.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `ld_valid` input, 1: a load beat is offered.
- `ld_ready` output, 1: the feeder accepts a beat this cycle.
- `ld_a` input, [k-1:0] x [0:D-1]: row r of A, where element c is A[r][c].
- `ld_b` input, [k-1:0] x [0:D-1]: column r of B, where element c is B[c][r].
- `in_l` output, [k-1:0] x [0:D-1]: left-edge operands, wired to `systolic_arr.in_l`.
- `in_t` output, [k-1:0] x [0:D-1]: top-edge operands, wired to `systolic_arr.in_t`.
- `arr_clr` output, 1: accumulator clear. The top level drives the array's `rst` with `rst | arr_clr`.
- `busy` output, 1: high in every state except LOAD.
- `done` output, 1: one-cycle pulse; C is valid on the array's `out` from this cycle on.

## Operation
- State machine: LOAD → CLEAR → STREAM → DRAIN → DONE → LOAD.
- LOAD:
  - `ld_ready`=1.
  - Each beat (`ld_valid & ld_ready`) writes `ld_a` to A buffer row r and `ld_b` to B buffer column r, with r = beat count 0..D-1.
  - Gaps in `ld_valid` are allowed.
  - The D-th beat moves the machine to CLEAR.
- CLEAR: lasts one cycle, with `arr_clr`=1 and `in_l`/`in_t` all zero.
- STREAM: lasts 2D-1 cycles, steps t = 0..2D-2.
  - `in_l[i]` = A[i][t-i] when 0 ≤ t-i < D, else 0.
  - `in_t[j]` = B[t-j][j] when 0 ≤ t-j < D, else 0.
- DRAIN: lasts DRAIN cycles, with all operand outputs zero.
- DONE: lasts one cycle with `done`=1, then the machine returns to LOAD.
- `ld_ready`=0 outside LOAD. A `ld_valid` outside LOAD is ignored and leaves the buffers unchanged.
- Buffers hold their contents until overwritten; a new load fully overwrites them.
- Step counter width is $clog2(2D). The skew test uses the signed difference t-i; wrap-around aliasing is forbidden.
- Reset, including reset mid-STREAM or mid-DRAIN:
  - The state returns to LOAD and the beat count to 0.
  - `in_l`, `in_t`, `arr_clr`, `busy` and `done` return to 0; `ld_ready` returns to 1 from the cycle after reset.
  - Buffer contents after reset are don't-care.

## Timing
- All outputs are registered. There is no combinational path from `ld_valid` to any output.
- Reset values: `ld_ready`=0 while `rst`=1, then 1. `in_l`, `in_t`, `arr_clr`, `busy` and `done` are all 0.
- Cycle-level timeline, counted from the last load beat accepted at the edge ending cycle n:
  - `arr_clr`=1 in cycle n+1.
  - Step t appears on `in_l`/`in_t` in cycle n+2+t.
  - DRAIN covers cycles n+2D+1 through n+2D+DRAIN.
  - `done` is in cycle n+2D+DRAIN+1.
  - `ld_ready` is high again in cycle n+2D+DRAIN+2.
- The feeder does not accept a load during processing, so there is no load/stream overlap. Throughput is one product per D + 2D + DRAIN + 1 cycles at minimum.

## Structure
- Shared package `systolic_pkg`:
  - State enum `feed_state_t` {LOAD, CLEAR, STREAM, DRAIN, DONE}.
  - Localparam helper for the step-counter width.
  - Default k and D shared with `systolic_arr`.
- Sub-module `systolic_skew_lane` (k, D): one lane's element select. Given lane index, step t and the buffered vector, it outputs the element or 0. It is instantiated 2D times, once per `in_l` lane and once per `in_t` lane.
- Top module contains the FSM, beat/step counters, both buffers and the output registers.

## Test plan
- Timeline, D=4, k=8, DRAIN=4, back-to-back beats in cycles 0-3 → `arr_clr` in cycle 4, steps in cycles 5-11, `done` in cycle 16 only, `ld_ready` high in cycle 17.
- Skew, A[r][c]=16r+c, B=A, D=4 → step 3: `in_l` = {0x03,0x12,0x21,0x30}. Step 6: `in_l` = {0,0,0,0x33}; `in_t`[3] = 0x33.
- Load gaps: `ld_valid` toggled every other cycle → the same buffered data and the same output sequence as back-to-back loading. A `ld_valid` during STREAM is ignored and the buffers are unchanged.
- Reset during STREAM step 2 → next cycle all outputs 0, `busy`=0, `ld_ready`=1. A following full load produces a correct run.
- Integration with `systolic_arr`, D=4: A all 1, B all 2 → every `out`[i][j]=8 at `done`. A = identity, B[r][c]=r+c → `out` equals B.
- Two consecutive runs with different A and B → the second result has no residue from the first, confirming `arr_clr` is effective.
